// File: rtl/led_pkg.sv
// Shared types for the LED pattern driver: pattern mode encoding and bounce direction.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_ALL    = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_COUNT  = 2'd3
    } led_mode_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/led_pwm.sv
// Free-running brightness PWM; all-ones duty forces the output permanently on.
module led_pwm #(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm_on
);

    localparam logic [PWM_BITS-1:0] DUTY_FULL = {PWM_BITS{1'b1}};

    logic [PWM_BITS-1:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    assign pwm_on = (duty == DUTY_FULL) | (pwm_cnt < duty);

endmodule

// File: rtl/led_pattern_driver.sv
// Turns rising edges of blink into pattern steps (off / all / bounce / count), PWM-gated onto leds.
module led_pattern_driver
    import led_pkg::*;
#(
    parameter int unsigned NUM_LEDS = 8,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned POS_W    = $clog2(NUM_LEDS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                blink,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] duty,
    output logic [NUM_LEDS-1:0] leds,
    output logic                step_tick,
    output logic [POS_W-1:0]    pos
);

    localparam logic [POS_W-1:0]    POS_TOP = POS_W'(NUM_LEDS - 1);
    localparam logic [NUM_LEDS-1:0] PAT_ONE = NUM_LEDS'(1);

    logic                blink_q;
    logic                rise;
    led_mode_t           mode_in;
    led_mode_t           mode_q;
    led_mode_t           mode_nxt;
    logic [NUM_LEDS-1:0] pat;
    logic [NUM_LEDS-1:0] pat_nxt;
    logic [POS_W-1:0]    pos_nxt;
    logic                dir;
    logic                dir_nxt;
    logic                pwm_on;

    assign rise    = blink & ~blink_q;
    assign mode_in = led_mode_t'(mode);

    led_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk    (clk),
        .rst_n  (rst_n),
        .duty   (duty),
        .pwm_on (pwm_on)
    );

    // A step with a new mode only loads that mode's start pattern; otherwise the pattern advances.
    always_comb begin
        mode_nxt = mode_q;
        pat_nxt  = pat;
        pos_nxt  = pos;
        dir_nxt  = dir;
        if (rise) begin
            if (mode_in != mode_q) begin
                mode_nxt = mode_in;
                pos_nxt  = '0;
                dir_nxt  = DIR_UP;
                case (mode_in)
                    MODE_OFF:    pat_nxt = '0;
                    MODE_ALL:    pat_nxt = '1;
                    MODE_BOUNCE: pat_nxt = PAT_ONE;
                    MODE_COUNT:  pat_nxt = '0;
                endcase
            end else begin
                case (mode_q)
                    MODE_OFF:    pat_nxt = '0;
                    MODE_ALL:    pat_nxt = '1;
                    MODE_BOUNCE: begin
                        // Turn around on the step that reaches an end, so ends are lit once per sweep.
                        if (dir == DIR_UP) begin
                            if (pos == POS_TOP) begin
                                dir_nxt = DIR_DOWN;
                                pos_nxt = pos - POS_W'(1);
                            end else begin
                                pos_nxt = pos + POS_W'(1);
                            end
                        end else begin
                            if (pos == '0) begin
                                dir_nxt = DIR_UP;
                                pos_nxt = pos + POS_W'(1);
                            end else begin
                                pos_nxt = pos - POS_W'(1);
                            end
                        end
                        pat_nxt = PAT_ONE << pos_nxt;
                    end
                    MODE_COUNT:  pat_nxt = pat + NUM_LEDS'(1);
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q   <= 1'b0;
            step_tick <= 1'b0;
            mode_q    <= MODE_OFF;
            pat       <= '0;
            pos       <= '0;
            dir       <= DIR_UP;
            leds      <= '0;
        end else begin
            blink_q   <= blink;
            step_tick <= rise;
            mode_q    <= mode_nxt;
            pat       <= pat_nxt;
            pos       <= pos_nxt;
            dir       <= dir_nxt;
            leds      <= pat & {NUM_LEDS{pwm_on}};
        end
    end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed plus random bench for led_pattern_driver against a step-count based reference model.
module tb_led_pattern_driver;

    localparam int N = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       blink = 1'b0;
    logic [1:0] mode  = 2'd0;
    logic [7:0] duty  = 8'hFF;
    logic [7:0] leds;
    logic       step_tick;
    logic [2:0] pos;

    int total = 0;
    int bad   = 0;
    int ticks = 0;
    int lit   = 0;

    // Reference model: pattern is a closed-form function of mode and steps since mode load.
    int         m_cnt;
    int         m_k;
    int         m_pos;
    logic [1:0] m_mode;
    logic       m_bq;
    logic       m_tick;
    logic [7:0] m_pat;
    logic [7:0] m_leds;

    always #5 clk = ~clk;

    led_pattern_driver #(
        .NUM_LEDS (N),
        .PWM_BITS (8),
        .POS_W    (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blink     (blink),
        .mode      (mode),
        .duty      (duty),
        .leds      (leds),
        .step_tick (step_tick),
        .pos       (pos)
    );

    function automatic int tri_pos(input int k);
        int p;
        p = k % (2 * (N - 1));
        return (p <= N - 1) ? p : 2 * (N - 1) - p;
    endfunction

    function automatic logic [7:0] pat_of(input logic [1:0] md, input int k);
        case (md)
            2'd0:    return 8'h00;
            2'd1:    return 8'hFF;
            2'd2:    return 8'(1 << tri_pos(k));
            default: return 8'(k % 256);
        endcase
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_k    = 0;
        m_pos  = 0;
        m_mode = 2'd0;
        m_bq   = 1'b0;
        m_tick = 1'b0;
        m_pat  = 8'h00;
        m_leds = 8'h00;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, model the edge, check #1 after it, return at the next negedge.
    task automatic step(input logic b, input logic [1:0] md, input logic [7:0] d);
        blink = b;
        mode  = md;
        duty  = d;
        @(posedge clk);
        m_leds = m_pat & {8{(d == 8'hFF) || ((m_cnt % 256) < int'(d))}};
        m_cnt++;
        m_tick = b & ~m_bq;
        m_bq   = b;
        if (m_tick) begin
            if (md != m_mode) begin
                m_mode = md;
                m_k    = 0;
            end else begin
                m_k++;
            end
        end
        m_pat = pat_of(m_mode, m_k);
        m_pos = (m_mode == 2'd2) ? tri_pos(m_k) : 0;
        #1;
        chk("leds", 32'(leds), 32'(m_leds));
        chk("step_tick", 32'(step_tick), 32'(m_tick));
        chk("pos", 32'(pos), 32'(m_pos));
        if (step_tick) ticks++;
        @(negedge clk);
    endtask

    task automatic pulse(input logic [1:0] md, input logic [7:0] d);
        step(1'b1, md, d);
        step(1'b0, md, d);
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("reset_leds", 32'(leds), 32'h0);
        chk("reset_tick", 32'(step_tick), 32'h0);
        chk("reset_pos", 32'(pos), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Bounce: load then nine advances, ending on the way back down.
        ticks = 0;
        for (int i = 0; i < 10; i++) pulse(2'd2, 8'hFF);
        chk("bounce_ticks", 32'(ticks), 32'd10);
        chk("bounce_pos", 32'(pos), 32'd5);
        chk("bounce_leds", 32'(leds), 32'h20);

        // Mode glitch between rises must not count as a mode change.
        step(1'b0, 2'd3, 8'hFF);
        step(1'b0, 2'd2, 8'hFF);
        step(1'b0, 2'd3, 8'hFF);
        step(1'b0, 2'd2, 8'hFF);
        pulse(2'd2, 8'hFF);
        chk("glitch_pos", 32'(pos), 32'd4);
        chk("glitch_leds", 32'(leds), 32'h10);

        // Sweep to position 6, then reset mid-sweep.
        for (int i = 0; i < 30 && m_pos != 6; i++) pulse(2'd2, 8'hFF);
        chk("sweep_pos", 32'(pos), 32'd6);
        rst_n = 1'b0;
        #1;
        chk("async_rst_leds", 32'(leds), 32'h0);
        chk("async_rst_pos", 32'(pos), 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulse(2'd2, 8'hFF);
        chk("reload_leds", 32'(leds), 32'h01);
        chk("reload_pos", 32'(pos), 32'h0);

        // Count: one load plus 256 advances wraps back to zero.
        ticks = 0;
        for (int i = 0; i < 257; i++) pulse(2'd3, 8'hFF);
        chk("count_ticks", 32'(ticks), 32'd257);
        chk("count_leds", 32'(leds), 32'h00);

        // Long blink high in ALL gives a single step.
        ticks = 0;
        step(1'b1, 2'd1, 8'hFF);
        step(1'b1, 2'd1, 8'hFF);
        chk("all_leds_two_edges", 32'(leds), 32'hFF);
        for (int i = 0; i < 48; i++) step(1'b1, 2'd1, 8'hFF);
        step(1'b0, 2'd1, 8'hFF);
        chk("hold_ticks", 32'(ticks), 32'd1);

        // Brightness: duty 0 is dark, duty 0x40 lights 64 of every 256 cycles.
        lit = 0;
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 2'd1, 8'h00);
            if (leds != 8'h00) lit++;
        end
        chk("duty0_lit", 32'(lit), 32'd0);
        lit = 0;
        for (int i = 0; i < 512; i++) begin
            step(1'b0, 2'd1, 8'h40);
            if (leds == 8'hFF) lit++;
        end
        chk("duty40_on", 32'(lit), 32'd128);

        // Random blink, mode and duty against the model.
        for (int i = 0; i < 800; i++) begin
            logic       rb;
            logic [1:0] rm;
            logic [7:0] rd;
            rb = ($urandom_range(0, 2) == 0);
            rm = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       rd = 8'hFF;
                1:       rd = 8'h00;
                default: rd = 8'($urandom_range(0, 255));
            endcase
            step(rb, rm, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
